// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Programmable serial-pattern detection controller. Configures, arms and
// sequences a Moore-style bit-stream detector with overlapping or
// non-overlapping matching, counts matches and stops after a programmed
// number of hits.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cfg_we       config write strobe (honoured only in IDLE)
//   cfg_pattern  pattern, bit [len-1] matched first, bit [0] last
//   cfg_len      pattern length, legal 2..PAT_W
//   cfg_overlap  1 = overlapping detection
//   cfg_target   match count that ends the run, 0 = run forever
//   start, stop  arm / abort requests (stop wins)
//   din_valid    qualifies din
//   din          serial data bit
//   dout         registered one-cycle match pulse
//   match_cnt    matches since the last start (saturating)
//   busy, done   state == RUN, state == DONE
//   cfg_err      sticky illegal-config flag
//
// state  | meaning
// S_IDLE | stopped, config writable
// S_RUN  | detecting
// S_DONE | target reached, results held
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             din_valid,
    input  logic             din,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0]       LEN_MAX = 4'(PAT_W);
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1001);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             dout_q, dout_d;
    logic             cfg_err_q, cfg_err_d;

    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] hist_shift;
    logic [3:0]       bitcnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             hit;

    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hist_shift = {hist_q[PAT_W-2:0], din};
        bitcnt_inc = (bitcnt_q >= len_q) ? len_q : bitcnt_q + 4'd1;
        cnt_sat    = (&match_cnt_q) ? match_cnt_q : match_cnt_q + 1'b1;
        // Needs len bits seen (counting the one arriving now) before comparing.
        hit        = din_valid && ((bitcnt_q + 4'd1) >= len_q)
                     && (((hist_shift ^ pat_q) & mask) == '0);
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        ovl_d       = ovl_q;
        tgt_d       = tgt_q;
        hist_d      = hist_q;
        bitcnt_d    = bitcnt_q;
        match_cnt_d = match_cnt_q;
        cfg_err_d   = cfg_err_q;
        dout_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    if (cfg_len >= 4'd2 && cfg_len <= LEN_MAX) begin
                        pat_d     = cfg_pattern;
                        len_d     = cfg_len;
                        ovl_d     = cfg_overlap;
                        tgt_d     = cfg_target;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (!stop && start) begin
                    state_d     = S_RUN;
                    hist_d      = '0;
                    bitcnt_d    = '0;
                    match_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    hist_d   = hist_shift;
                    bitcnt_d = bitcnt_inc;
                    if (hit) begin
                        dout_d      = 1'b1;
                        match_cnt_d = cnt_sat;
                        if (!ovl_q) begin
                            bitcnt_d = '0;
                        end
                        if (tgt_q != '0 && cnt_sat == tgt_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d     = S_RUN;
                    hist_d      = '0;
                    bitcnt_d    = '0;
                    match_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pat_q       <= PAT_RST;
            len_q       <= 4'd4;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            hist_q      <= '0;
            bitcnt_q    <= '0;
            match_cnt_q <= '0;
            dout_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ovl_q       <= ovl_d;
            tgt_q       <= tgt_d;
            hist_q      <= hist_d;
            bitcnt_q    <= bitcnt_d;
            match_cnt_q <= match_cnt_d;
            dout_q      <= dout_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign dout      = dout_q;
    assign match_cnt = match_cnt_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller. It configures, arms and sequences a Moore-style bit-stream pattern detector, and supports both overlapping and non-overlapping match modes. It counts matches and stops automatically after a programmed number of hits. It sits between a register/config interface and the serial data path. The default configuration detects "1001" in non-overlapping mode.

Parameters:
PAT_W, 8, maximum pattern length in bits (supported range 2..PAT_W)
CNT_W, 8, width of the match counter and the target register

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cfg_we  input  1  configuration write strobe; honoured only in IDLE
cfg_pattern  input  PAT_W  pattern; bit [len-1] is matched first, bit [0] last
cfg_len  input  4  pattern length; legal values are 2..PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CNT_W  match count at which the run ends; 0 = run forever
start  input  1  arm/run request (level sampled each cycle)
stop  input  1  abort request (level sampled each cycle)
din_valid  input  1  din is sampled only when this is 1
din  input  1  serial data bit
dout  output  1  registered 1-cycle match pulse
match_cnt  output  CNT_W  matches since the last start
busy  output  1  1 while in RUN
done  output  1  1 while in DONE
cfg_err  output  1  sticky illegal-config flag

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE.
  - dout=0, match_cnt=0, busy=0, done=0, cfg_err=0.
  - History shift register = 0, bit counter = 0.
  - Config registers: pattern = 4'b1001 zero-extended, len=4, overlap=0, target=0.
  - Asserting reset mid-run aborts immediately; no partial state survives.
- FSM states:
  - IDLE: config writable.
  - RUN: detecting.
  - DONE: target reached, holding results.
- Configuration:
  - cfg_we in IDLE with cfg_len in 2..PAT_W: all four config registers load on that edge, and cfg_err clears.
  - cfg_we in IDLE with an illegal cfg_len: config registers unchanged, cfg_err is set.
  - cfg_we in RUN or DONE: ignored; no error flagged.
- Transitions (stop has priority over start on the same edge):
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop; match_cnt is retained.
  - RUN -> DONE when a match brings match_cnt equal to a non-zero target.
  - DONE -> RUN on start.
  - DONE -> IDLE on stop.
  - Every entry into RUN clears match_cnt, the history register and the bit counter.
- Detection (RUN only, on edges with din_valid=1):
  - history <= {history[PAT_W-2:0], din}.
  - Bit counter increments, saturating at len.
  - A match occurs when (bit counter + 1) >= len and history_next[len-1:0] == pattern[len-1:0].
  - din_valid=0: no shift, no count, no match.
- On a match:
  - dout=1 for exactly one cycle, from the edge after the matching bit was sampled (Moore: dout comes from a registered hit state, never combinational from din).
  - match_cnt increments on the same edge; at all-ones it saturates and does not wrap.
  - Non-overlap mode: bit counter resets to 0, so the next match needs len fresh bits.
  - Overlap mode: bit counter is unchanged.
- Terminal match: done rises and busy falls on the same edge as the final dout pulse.
- Output meanings: busy = (state==RUN); done = (state==DONE).
- Outside RUN: din is ignored and dout=0.

Test Plan:
1. Default config; start; feed 1,0,0,1,0,0,1 with din_valid=1 -> one dout pulse, in the cycle after the 4th bit; match_cnt=1; busy stays 1.
2. Write cfg_overlap=1 (len=4, pattern=1001); start; feed the same 7 bits -> dout pulses after bits 4 and 7; match_cnt=2.
3. Write cfg_target=2 (non-overlap, 1001); start; feed 1001 0 1001 -> second pulse coincides with done=1, busy=0; further din has no effect; match_cnt=2.
4. In IDLE, cfg_we with cfg_len=1 -> cfg_err=1, and a subsequent run still detects 1001. Then cfg_we with len=3, pattern=3'b101, overlap=1, feeding 10101 -> 2 matches, cfg_err=0.
5. Default config; feed 1,0,(din_valid=0 for 3 cycles with din=1),0,1 -> exactly one match; the idle cycles are not shifted in.
6. During RUN: assert start and stop together -> IDLE, match_cnt retained. Restart, feed 1,0,0, pull reset low -> all outputs 0 immediately. Release reset, start, feed 1 -> no match (history cleared).
